// File: rtl/basic_homework11.sv
// Presettable synchronous binary counter (74161-style) with terminal-count carry.
// Latency: load/count take effect one CLK edge later; MR clears Q asynchronously; CO is combinational from Q.
// Backpressure: none; EN stalls the count, and BASIC_HOMEWORK11_CO_GATE_EN gates CO with EN when defined.
module basic_homework11 #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             LOAD,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  // Last value of the count sequence; also the wrap threshold.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_hit;

  // Next count: load beats enable.
  // Values at or above TERM wrap to zero, so out-of-range loads recover on the next count.
  always_comb begin
    q_d = q_q;
    if (!LOAD) begin
      q_d = D;
    end else if (EN) begin
      if (q_q >= TERM) begin
        q_d = '0;
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  // Count register; MR clears it immediately and holds it at zero while low.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign tc_hit = (q_q == TERM);
  assign Q      = q_q;

`ifdef BASIC_HOMEWORK11_CO_GATE_EN
  // Ripple-enable cascades need the carry to drop whenever this stage is not counting.
  assign CO = tc_hit & EN;
`else
  assign CO = tc_hit;
`endif

endmodule

// File: tb/tb_basic_homework11.sv
// Self-checking bench for basic_homework11: vector table, multi-cycle corner sequences,
// a two-stage cascade and a modulo-10 instance. Expected values are queued at drive
// time and popped when the output is sampled.
module tb_basic_homework11;

  logic       clk;
  logic       mr;
  logic       ld_n;
  logic       en;
  logic [3:0] d;
  logic [3:0] q;
  logic       co;

  // Cascade pair.
  logic       cas_ld_n;
  logic       cas_en;
  logic [3:0] lo_d;
  logic [3:0] hi_d;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_co;
  logic       hi_co;

  // Modulo-10 instance.
  logic       dec_ld_n;
  logic       dec_en;
  logic [3:0] dec_d;
  logic [3:0] dec_q;
  logic       dec_co;

  int total = 0;
  int bad   = 0;

  basic_homework11 dut (
    .CLK(clk), .MR(mr), .LOAD(ld_n), .EN(en), .D(d), .Q(q), .CO(co)
  );

  basic_homework11 u_lo (
    .CLK(clk), .MR(mr), .LOAD(cas_ld_n), .EN(cas_en), .D(lo_d), .Q(lo_q), .CO(lo_co)
  );

  basic_homework11 u_hi (
    .CLK(clk), .MR(mr), .LOAD(cas_ld_n), .EN(lo_co), .D(hi_d), .Q(hi_q), .CO(hi_co)
  );

  basic_homework11 #(.WIDTH(4), .MODULUS(10)) u_dec (
    .CLK(clk), .MR(mr), .LOAD(dec_ld_n), .EN(dec_en), .D(dec_d), .Q(dec_q), .CO(dec_co)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       ld_n;
    logic       en;
    logic [3:0] d;
    logic [3:0] eq;
    logic       eco;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       co;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue an expectation for the main counter.
  task automatic push(input string name, input logic [3:0] eq, input logic eco);
    exp_t e;
    e.name = name;
    e.q    = eq;
    e.co   = eco;
    sb.push_back(e);
  endtask

  // Compare the main counter against the oldest queued expectation.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_q"}, 32'(q), 32'(e.q));
      chk({e.name, "_co"}, 32'(co), 32'(e.co));
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the stimulus is bounded, but never let the run hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mr = 1'b0; ld_n = 1'b1; en = 1'b0; d = 4'h0;
    cas_ld_n = 1'b1; cas_en = 1'b0; lo_d = 4'h0; hi_d = 4'h0;
    dec_ld_n = 1'b1; dec_en = 1'b0; dec_d = 4'h0;

    //             ld_n  en    d      q      co
    vecs[0]  = '{1'b0, 1'b0, 4'hA, 4'hA, 1'b0};  // load
    vecs[1]  = '{1'b1, 1'b1, 4'h0, 4'hB, 1'b0};  // count
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'hC, 1'b0};  // count
    vecs[3]  = '{1'b1, 1'b0, 4'h5, 4'hC, 1'b0};  // hold
    vecs[4]  = '{1'b1, 1'b0, 4'h5, 4'hC, 1'b0};  // hold
    vecs[5]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1};  // load wins over enable
    vecs[6]  = '{1'b0, 1'b1, 4'h3, 4'h3, 1'b0};  // load wins over enable
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'h4, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'hE, 4'hE, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b1};  // reach terminal count
    vecs[10] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0};  // wrap
    vecs[11] = '{1'b1, 1'b1, 4'h0, 4'h1, 1'b0};

    // Power-up reset, no clock edge yet.
    #2;
    push("powerup", 4'h0, 1'b0);
    pop_check();
    chk("powerup_dec_q", 32'(dec_q), 32'd0);
    chk("powerup_dec_co", 32'(dec_co), 32'd0);

    @(negedge clk);
    mr = 1'b1;

    // Table-driven vectors: drive on the falling edge, sample after the rising edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ld_n = vecs[i].ld_n;
      en   = vecs[i].en;
      d    = vecs[i].d;
      push($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eco);
      edge_sample();
      pop_check();
    end

    // Terminal count with enable low, then raised between edges.
    @(negedge clk);
    ld_n = 1'b0; en = 1'b0; d = 4'hF;
    edge_sample();
`ifdef BASIC_HOMEWORK11_CO_GATE_EN
    push("tc_en0", 4'hF, 1'b0);
`else
    push("tc_en0", 4'hF, 1'b1);
`endif
    pop_check();
    @(negedge clk);
    ld_n = 1'b1; en = 1'b1;
    #1;
    push("tc_en1", 4'hF, 1'b1);
    pop_check();
    #1;
    en = 1'b0;
    #1;
`ifdef BASIC_HOMEWORK11_CO_GATE_EN
    push("tc_endrop", 4'hF, 1'b0);
`else
    push("tc_endrop", 4'hF, 1'b1);
`endif
    pop_check();
    en = 1'b1;
    edge_sample();
    push("tc_wrap", 4'h0, 1'b0);
    pop_check();

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    ld_n = 1'b0; en = 1'b0; d = 4'hC;
    edge_sample();
    push("pre_reset", 4'hC, 1'b0);
    pop_check();
    #2;
    mr = 1'b0;
    #1;
    push("async_reset", 4'h0, 1'b0);
    pop_check();
    @(negedge clk);
    ld_n = 1'b0; en = 1'b1; d = 4'h7;
    edge_sample();
    push("reset_load", 4'h0, 1'b0);
    pop_check();
    @(negedge clk);
    ld_n = 1'b1;
    edge_sample();
    push("reset_count", 4'h0, 1'b0);
    pop_check();
    @(negedge clk);
    mr = 1'b1;
    edge_sample();
    push("post_reset", 4'h1, 1'b0);
    pop_check();

    // Cascade: upper stage advances on the edge where the lower one wraps.
    @(negedge clk);
    cas_ld_n = 1'b0; cas_en = 1'b0; lo_d = 4'hE; hi_d = 4'h5;
    edge_sample();
    chk("cas_load_lo", 32'(lo_q), 32'hE);
    chk("cas_load_hi", 32'(hi_q), 32'h5);
    @(negedge clk);
    cas_ld_n = 1'b1; cas_en = 1'b1;
    edge_sample();
    chk("cas1_lo", 32'(lo_q), 32'hF);
    chk("cas1_hi", 32'(hi_q), 32'h5);
    chk("cas1_lo_co", 32'(lo_co), 32'd1);
    edge_sample();
    chk("cas2_lo", 32'(lo_q), 32'h0);
    chk("cas2_hi", 32'(hi_q), 32'h6);
    edge_sample();
    chk("cas3_lo", 32'(lo_q), 32'h1);
    chk("cas3_hi", 32'(hi_q), 32'h6);

    // Modulo-10: terminal count at 9, out-of-range load wraps on next count.
    @(negedge clk);
    dec_ld_n = 1'b0; dec_en = 1'b0; dec_d = 4'd8;
    edge_sample();
    chk("dec_load8", 32'(dec_q), 32'd8);
    chk("dec_load8_co", 32'(dec_co), 32'd0);
    @(negedge clk);
    dec_ld_n = 1'b1; dec_en = 1'b1;
    edge_sample();
    chk("dec_9", 32'(dec_q), 32'd9);
    chk("dec_9_co", 32'(dec_co), 32'd1);
    edge_sample();
    chk("dec_wrap", 32'(dec_q), 32'd0);
    chk("dec_wrap_co", 32'(dec_co), 32'd0);
    @(negedge clk);
    dec_ld_n = 1'b0; dec_d = 4'd12;
    edge_sample();
    chk("dec_load12", 32'(dec_q), 32'd12);
    chk("dec_load12_co", 32'(dec_co), 32'd0);
    @(negedge clk);
    dec_ld_n = 1'b1;
    edge_sample();
    chk("dec_oob_wrap", 32'(dec_q), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
